// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the ALU flag interface: the 16 condition codes, the
// architectural flag vector {V,N,Z,C} and the bit positions inside it.
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Field order matches the ALU flag vector: bit3 V, bit2 N, bit1 Z, bit0 C.
    typedef struct packed {
        logic v;
        logic n;
        logic z;
        logic c;
    } flags_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational condition-code evaluator.
//   cond_i  : 4-bit condition code (alu_pkg::cond_e encoding)
//   flags_i : architectural flags {V,N,Z,C}
//   pass_o  : 1 when the condition holds for the given flags
// ---------------------------------------------------------------------------
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    cond_e  cond;
    flags_t flg;

    assign cond = cond_e'(cond_i);
    assign flg  = flags_t'(flags_i);

    always_comb begin
        // NOTE: default assignment first so no path through the case can
        // leave pass_o unassigned and infer a latch.
        pass_o = 1'b0;
        case (cond)
            COND_EQ: pass_o = flg.z;
            COND_NE: pass_o = !flg.z;
            COND_CS: pass_o = flg.c;
            COND_CC: pass_o = !flg.c;
            COND_MI: pass_o = flg.n;
            COND_PL: pass_o = !flg.n;
            COND_VS: pass_o = flg.v;
            COND_VC: pass_o = !flg.v;
            COND_HI: pass_o = flg.c & !flg.z;
            COND_LS: pass_o = !flg.c | flg.z;
            COND_GE: pass_o = (flg.n == flg.v);
            COND_LT: pass_o = (flg.n != flg.v);
            COND_GT: pass_o = !flg.z & (flg.n == flg.v);
            COND_LE: pass_o = flg.z | (flg.n != flg.v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;   // reserved: never executes
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_cond_unit.sv
// ---------------------------------------------------------------------------
// alu_cond_unit
// Consumer end of the ALU flag interface. Each accepted operation is
// predicated on the current flag register, optionally updates the flags
// (only when executed), and is presented through a one-entry valid/ready
// output register. Saturating executed/skipped counters aid debug.
//   clk, rst_n                : clock, synchronous active-low reset
//   in_valid / in_ready       : input handshake
//   in_cond, in_set_flags,
//   in_alu_flags, in_result   : operation payload
//   out_valid / out_ready     : output handshake
//   out_exec, out_result      : predicate outcome and registered result
//   flags_q                   : architectural flags {V,N,Z,C}
//   exec_cnt, skip_cnt        : saturating operation counters
// ---------------------------------------------------------------------------
module alu_cond_unit
    import alu_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cond,
    input  logic             in_set_flags,
    input  logic [3:0]       in_alu_flags,
    input  logic [N-1:0]     in_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_exec,
    output logic [N-1:0]     out_result,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    logic             out_valid_q, out_valid_d;
    logic             out_exec_q,  out_exec_d;
    logic [N-1:0]     out_result_q, out_result_d;
    logic [3:0]       flags_d;
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
    logic             pass;
    logic             accept;

    cond_eval u_cond_eval (
        .cond_i  (in_cond),
        .flags_i (flags_q),
        .pass_o  (pass)
    );

    // The single output register frees up in the same cycle it is drained,
    // so the input side sees out_ready combinationally.
    assign in_ready = !out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_exec_d   = out_exec_q;
        out_result_d = out_result_q;
        flags_d      = flags_q;
        exec_cnt_d   = exec_cnt_q;
        skip_cnt_d   = skip_cnt_q;

        if (accept) begin
            out_valid_d  = 1'b1;
            out_exec_d   = pass;
            out_result_d = in_result;
            if (pass && in_set_flags) begin
                flags_d = in_alu_flags;
            end
            if (pass) begin
                if (exec_cnt_q != '1) exec_cnt_d = exec_cnt_q + 1'b1;
            end else begin
                if (skip_cnt_q != '1) skip_cnt_d = skip_cnt_q + 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            // Drain: payload registers keep their last value.
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_exec_q   <= 1'b0;
            out_result_q <= '0;
            flags_q      <= 4'b0000;
            exec_cnt_q   <= '0;
            skip_cnt_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_exec_q   <= out_exec_d;
            out_result_q <= out_result_d;
            flags_q      <= flags_d;
            exec_cnt_q   <= exec_cnt_d;
            skip_cnt_q   <= skip_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_exec   = out_exec_q;
    assign out_result = out_result_q;
    assign exec_cnt   = exec_cnt_q;
    assign skip_cnt   = skip_cnt_q;

endmodule

// File: tb/tb_alu_cond_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_cond_unit
// Scoreboarded bench: the stimulus process pushes the expected output of
// every accepted operation; a monitor pops and compares on each output
// transfer. A second instance with 3-bit counters exercises saturation.
// ---------------------------------------------------------------------------
module tb_alu_cond_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cond;
    logic        in_set_flags;
    logic [3:0]  in_alu_flags;
    logic [3:0]  in_result;
    logic        out_valid;
    logic        out_ready;
    logic        out_exec;
    logic [3:0]  out_result;
    logic [3:0]  flags_q;
    logic [15:0] exec_cnt;
    logic [15:0] skip_cnt;

    logic        sat_in_ready, sat_out_valid, sat_out_exec;
    logic [3:0]  sat_out_result, sat_flags_q;
    logic [2:0]  sat_exec_cnt, sat_skip_cnt;

    always #5 clk = ~clk;

    alu_cond_unit #(.N(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cond(in_cond), .in_set_flags(in_set_flags),
        .in_alu_flags(in_alu_flags), .in_result(in_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exec(out_exec), .out_result(out_result),
        .flags_q(flags_q), .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
    );

    alu_cond_unit #(.N(4), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_cond(in_cond), .in_set_flags(in_set_flags),
        .in_alu_flags(in_alu_flags), .in_result(in_result),
        .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_exec(sat_out_exec), .out_result(sat_out_result),
        .flags_q(sat_flags_q), .exec_cnt(sat_exec_cnt), .skip_cnt(sat_skip_cnt)
    );

    typedef struct {
        logic       ex;
        logic [3:0] res;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] m_flags  = 4'b0000;
    int         m_exec   = 0;
    int         m_skip   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference condition model, written from the condition table.
    function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
        logic v, n, z, cy;
        {v, n, z, cy} = f;
        case (c)
            4'h0: return z;
            4'h1: return ~z;
            4'h2: return cy;
            4'h3: return ~cy;
            4'h4: return n;
            4'h5: return ~n;
            4'h6: return v;
            4'h7: return ~v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n ~^ v;
            4'hB: return n ^ v;
            4'hC: return !z && (n ~^ v);
            4'hD: return z || (n ^ v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Output monitor: one pop per output transfer.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_exec", {31'd0, out_exec}, {31'd0, e.ex});
                check("out_result", {28'd0, out_result}, {28'd0, e.res});
            end
        end
    end

    // Drive an operation and hold it until accepted. Called at posedge+1;
    // returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [3:0] c, input logic s, input logic [3:0] f,
                         input logic [3:0] r, input logic exp_ex);
        int waits;
        exp_t e;
        waits        = 0;
        in_valid     = 1'b1;
        in_cond      = c;
        in_set_flags = s;
        in_alu_flags = f;
        in_result    = r;
        @(negedge clk);
        while (in_ready !== 1'b1 && waits < 50) begin
            waits++;
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(negedge clk);
        end
        if (waits >= 50) begin
            check("accept_timeout", 32'd1, 32'd0);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.ex  = exp_ex;
        e.res = r;
        sb_q.push_back(e);
        if (exp_ex && s) m_flags = f;
        if (exp_ex) m_exec++;
        else        m_skip++;
        #1 in_valid = 1'b0;
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, "_flags"}, {28'd0, flags_q}, {28'd0, m_flags});
        check({tag, "_exec_cnt"}, {16'd0, exec_cnt}, m_exec);
        check({tag, "_skip_cnt"}, {16'd0, skip_cnt}, m_skip);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] c, f, r;
        logic       s, ex;

        rst_n = 1'b0; in_valid = 1'b0; in_cond = 4'h0; in_set_flags = 1'b0;
        in_alu_flags = 4'h0; in_result = 4'h0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_exec", {31'd0, out_exec}, 32'd0);
        check("rst_out_result", {28'd0, out_result}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_flags", {28'd0, flags_q}, 32'd0);
        check("rst_exec_cnt", {16'd0, exec_cnt}, 32'd0);
        check("rst_skip_cnt", {16'd0, skip_cnt}, 32'd0);
        @(posedge clk); #1;

        // 5-5: Z=1, C=1
        issue(4'hE, 1'b1, 4'b0011, 4'b0000, 1'b1);
        check_state("sub_eq");
        issue(4'h0, 1'b0, 4'b0000, 4'h1, 1'b1);   // EQ executes
        issue(4'h1, 1'b0, 4'b0000, 4'h2, 1'b0);   // NE skips

        // 3-5: N=1
        issue(4'hE, 1'b1, 4'b0100, 4'b1110, 1'b1);
        issue(4'hB, 1'b0, 4'b0000, 4'h3, 1'b1);   // LT executes
        issue(4'hA, 1'b0, 4'b0000, 4'h4, 1'b0);   // GE skips
        check_state("sub_lt");

        // 7+1: V=1, N=1
        issue(4'hE, 1'b1, 4'b1100, 4'b1000, 1'b1);
        issue(4'hA, 1'b0, 4'b0000, 4'h5, 1'b1);   // GE
        issue(4'hC, 1'b0, 4'b0000, 4'h6, 1'b1);   // GT
        issue(4'h6, 1'b0, 4'b0000, 4'h7, 1'b1);   // VS
        check_state("add_ovf");

        // Skipped flag-setter leaves flags alone
        issue(4'hE, 1'b1, 4'b0011, 4'h8, 1'b1);
        issue(4'h1, 1'b1, 4'b0100, 4'h9, 1'b0);
        check_state("skip_set");
        check("skip_set_flags_hand", {28'd0, flags_q}, 32'h3);

        // NV with set never executes
        issue(4'hF, 1'b1, 4'b1111, 4'hA, 1'b0);
        check_state("nv");
        check("nv_flags_hand", {28'd0, flags_q}, 32'h3);

        // Backpressure: hold op A in the output, B waits
        out_ready = 1'b0;
        issue(4'hE, 1'b0, 4'b0000, 4'hB, 1'b1);
        in_valid = 1'b1; in_cond = 4'hE; in_set_flags = 1'b0; in_result = 4'hC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_out_result", {28'd0, out_result}, 32'hB);
            check("hold_exec_cnt", {16'd0, exec_cnt}, m_exec);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        issue(4'hE, 1'b0, 4'b0000, 4'hC, 1'b1);

        // Random stream with random downstream readiness
        for (int i = 0; i < 20; i++) begin
            c  = 4'($urandom_range(0, 15));
            s  = 1'($urandom_range(0, 1));
            f  = 4'($urandom_range(0, 15));
            r  = 4'($urandom_range(0, 15));
            ex = model_pass(c, m_flags);
            out_ready = 1'($urandom_range(0, 1));
            issue(c, s, f, r, ex);
        end
        out_ready = 1'b1;
        check_state("random");

        // Reset while output is held and a flag-setting op is presented
        out_ready = 1'b0;
        issue(4'hE, 1'b1, 4'b1010, 4'hD, 1'b1);
        in_valid = 1'b1; in_cond = 4'hE; in_set_flags = 1'b1;
        in_alu_flags = 4'b0101; in_result = 4'hE;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sb_q.delete();
        m_flags = 4'b0000; m_exec = 0; m_skip = 0;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_flags", {28'd0, flags_q}, 32'd0);
        check("midrst_exec_cnt", {16'd0, exec_cnt}, 32'd0);
        @(posedge clk); #1;

        // Saturation on the 3-bit-counter instance
        for (int i = 0; i < 10; i++) begin
            issue(4'hE, 1'b0, 4'b0000, 4'(i), 1'b1);
        end
        check_state("sat");
        check("sat_exec_cnt", {29'd0, sat_exec_cnt}, 32'd7);
        check("sat_skip_cnt", {29'd0, sat_skip_cnt}, 32'd0);

        // Drain
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        check("drain_sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
